// File: rtl/tpu_bridge_pkg.sv
// Shared types and helpers for the TPU host bridge.
// Widths here bound the top-level parameters (DATA_W, ADDR_W, REGION_IDX_W).
package tpu_bridge_pkg;

  localparam int BR_ADDR_W = 64;
  localparam int BR_DATA_W = 64;
  localparam int BR_IDX_W  = 4;

  typedef struct packed {
    logic [BR_DATA_W-1:0] rdata;
    logic                 err;
    logic                 is_write;
  } rsp_entry_t;

  typedef struct packed {
    logic                valid;
    logic [BR_IDX_W-1:0] idx;
    logic                err;
    logic                we;
  } pipe_entry_t;

  function automatic logic [BR_IDX_W-1:0] region_idx(input logic [BR_ADDR_W-1:0] addr,
                                                     input int unsigned         shift);
    return BR_IDX_W'(addr >> shift);
  endfunction

endpackage

// File: rtl/tpu_bridge_rsp_fifo.sv
// Synchronous response FIFO of rsp_entry_t with occupancy count.
// Head entry reads as zero while empty.
module tpu_bridge_rsp_fifo
  import tpu_bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  rsp_entry_t       din,
  input  logic             pop,
  output logic             valid,
  output rsp_entry_t       dout,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign dout   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && int'(count) == DEPTH));

endmodule

// File: rtl/tpu_host_bridge.sv
// Host-side bridge: decodes single-beat requests onto NUM_REGIONS slave ports and returns
// in-order responses through a credit-managed FIFO. Optional: TPU_BRIDGE_ERRLOG_EN.
module tpu_host_bridge
  import tpu_bridge_pkg::*;
#(
  parameter int NUM_REGIONS  = 3,
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int LOCAL_ADDR_W = 16,
  parameter int REGION_SHIFT = 16,
  parameter int REGION_IDX_W = 4,
  parameter int RD_LATENCY   = 1,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_we,
  input  logic [ADDR_W-1:0]                   req_addr,
  input  logic [DATA_W-1:0]                   req_wdata,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [DATA_W-1:0]                   rsp_rdata,
  output logic                                rsp_err,
  output logic                                rsp_is_write,
  output logic [NUM_REGIONS-1:0]              region_en,
  output logic                                region_we,
  output logic [LOCAL_ADDR_W-1:0]             region_addr,
  output logic [DATA_W-1:0]                   region_wdata,
  input  logic [NUM_REGIONS-1:0][DATA_W-1:0]  region_rdata
`ifdef TPU_BRIDGE_ERRLOG_EN
  ,
  output logic [ADDR_W-1:0]                   err_addr,
  output logic                                err_seen
`endif
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [BR_IDX_W-1:0] IDX_MASK = BR_IDX_W'((1 << REGION_IDX_W) - 1);

  logic [BR_IDX_W-1:0] idx_p0;
  logic                err_p0;
  logic                acc_p0;
  pipe_entry_t         issue_p1;
  pipe_entry_t         ret_p2 [RD_LATENCY];
  pipe_entry_t         last_p2;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    inflight;
  logic [DATA_W-1:0]   sel_rdata;
  rsp_entry_t          push_entry;
  rsp_entry_t          head_entry;
  logic                push;

  // Stage p0: decode and credit check
  assign idx_p0 = region_idx(BR_ADDR_W'(req_addr), REGION_SHIFT) & IDX_MASK;
  assign err_p0 = (int'(idx_p0) >= NUM_REGIONS);
  assign acc_p0 = req_valid && req_ready;

  always_comb begin
    inflight = CNT_W'(issue_p1.valid);
    for (int s = 0; s < RD_LATENCY; s++) inflight += CNT_W'(ret_p2[s].valid);
  end

  assign req_ready = !rst && (int'(fifo_count) + int'(inflight) + 1 <= RSP_DEPTH);

  // Stage p1: issue strobe; stage p2: return pipe matching slave read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_p1     <= '0;
      region_en    <= '0;
      region_we    <= 1'b0;
      region_addr  <= '0;
      region_wdata <= '0;
      for (int s = 0; s < RD_LATENCY; s++) ret_p2[s] <= '0;
    end else begin
      issue_p1.valid <= acc_p0;
      issue_p1.idx   <= idx_p0;
      issue_p1.err   <= err_p0;
      issue_p1.we    <= req_we;
      for (int r = 0; r < NUM_REGIONS; r++)
        region_en[r] <= acc_p0 && !err_p0 && (idx_p0 == BR_IDX_W'(r));
      if (acc_p0) begin
        region_we    <= req_we;
        region_addr  <= req_addr[LOCAL_ADDR_W-1:0];
        region_wdata <= req_wdata;
      end
      ret_p2[0] <= issue_p1;
      for (int s = 1; s < RD_LATENCY; s++) ret_p2[s] <= ret_p2[s-1];
    end
  end

  // Stage p2 exit: capture slave data into the response FIFO
  assign last_p2 = ret_p2[RD_LATENCY-1];
  assign push    = last_p2.valid;

  always_comb begin
    sel_rdata = '0;
    for (int r = 0; r < NUM_REGIONS; r++)
      if (last_p2.idx == BR_IDX_W'(r)) sel_rdata = region_rdata[r];
    push_entry.rdata    = (last_p2.we || last_p2.err) ? '0 : BR_DATA_W'(sel_rdata);
    push_entry.err      = last_p2.err;
    push_entry.is_write = last_p2.we;
  end

  tpu_bridge_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (rsp_ready),
    .valid (rsp_valid),
    .dout  (head_entry),
    .count (fifo_count)
  );

  assign rsp_rdata    = DATA_W'(head_entry.rdata);
  assign rsp_err      = head_entry.err;
  assign rsp_is_write = head_entry.is_write;

`ifdef TPU_BRIDGE_ERRLOG_EN
  // First unmapped access wins; later errors leave the log untouched until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_seen <= 1'b0;
      err_addr <= '0;
    end else if (acc_p0 && err_p0 && !err_seen) begin
      err_seen <= 1'b1;
      err_addr <= req_addr;
    end
  end
`endif

endmodule

// File: tb/tb_tpu_host_bridge.sv
// Self-checking bench for tpu_host_bridge: directed vector table, backpressure, reset
// and randomized traffic against a reference memory model and response scoreboard.
module tb_tpu_host_bridge;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [63:0]       req_addr = '0;
  logic [63:0]       req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_is_write;
  logic [2:0]        region_en;
  logic              region_we;
  logic [15:0]       region_addr;
  logic [63:0]       region_wdata;
  logic [2:0][63:0]  region_rdata;
`ifdef TPU_BRIDGE_ERRLOG_EN
  logic [63:0]       err_addr;
  logic              err_seen;
`endif

  int total = 0;
  int bad   = 0;
  logic mem_init = 1'b1;

  always #5 clk = ~clk;

  tpu_host_bridge #(
    .NUM_REGIONS(3), .ADDR_W(64), .DATA_W(64), .LOCAL_ADDR_W(16),
    .REGION_SHIFT(16), .REGION_IDX_W(4), .RD_LATENCY(1), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_is_write(rsp_is_write),
    .region_en(region_en), .region_we(region_we), .region_addr(region_addr),
    .region_wdata(region_wdata), .region_rdata(region_rdata)
`ifdef TPU_BRIDGE_ERRLOG_EN
    , .err_addr(err_addr), .err_seen(err_seen)
`endif
  );

  function automatic logic [63:0] init_val(input int r, input int i);
    if (r == 2 && i == 0) return 64'h1;
    return 64'hA000_0000_0000_0000 | 64'(r << 8) | 64'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave fixture: 16-word memories, read data one cycle after the strobe.
  logic [63:0] smem [3][16];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int r = 0; r < 3; r++) begin
        region_rdata[r] <= '0;
        for (int i = 0; i < 16; i++) smem[r][i] <= init_val(r, i);
      end
    end else begin
      for (int r = 0; r < 3; r++)
        if (region_en[r]) begin
          if (region_we) smem[r][region_addr[3:0]] <= region_wdata;
          else           region_rdata[r] <= smem[r][region_addr[3:0]];
        end
    end
  end

  // Reference model: memory state tracked in acceptance order, responses queued.
  typedef struct { logic [63:0] rdata; logic err; logic we; } exp_t;
  exp_t        exp_q[$];
  logic [63:0] ref_mem [3][16];
  logic [2:0]  exp_en = '0;
  logic [15:0] exp_addr = '0;
  logic        exp_we = 1'b0;
  logic [63:0] exp_wdata = '0;
  logic        stall_prev = 1'b0;
  logic [63:0] stall_data = '0;
  logic        stall_err = 1'b0;
  logic        stall_w = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int   idx;
    if (mem_init)
      for (int r = 0; r < 3; r++)
        for (int i = 0; i < 16; i++) ref_mem[r][i] = init_val(r, i);

    chk("strobe_region_en", 64'(region_en), 64'(exp_en));
    if (exp_en != 3'b000) begin
      chk("strobe_region_addr", 64'(region_addr), 64'(exp_addr));
      chk("strobe_region_we", 64'(region_we), 64'(exp_we));
      if (exp_we) chk("strobe_region_wdata", region_wdata, exp_wdata);
    end

    exp_en = 3'b000;
    if (req_valid && req_ready) begin
      idx   = int'(req_addr[19:16]);
      e.err = (idx >= 3);
      e.we  = req_we;
      e.rdata = '0;
      if (!e.err) begin
        exp_en    = 3'(1 << idx);
        exp_addr  = req_addr[15:0];
        exp_we    = req_we;
        exp_wdata = req_wdata;
        if (req_we) ref_mem[idx][req_addr[3:0]] = req_wdata;
        else        e.rdata = ref_mem[idx][req_addr[3:0]];
      end
      exp_q.push_back(e);
    end

    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(rsp_valid), 64'(1));
        chk("stall_rdata", rsp_rdata, stall_data);
        chk("stall_flags", 64'({rsp_err, rsp_is_write}), 64'({stall_err, stall_w}));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_is_write", 64'(rsp_is_write), 64'(e.we));
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      stall_data = rsp_rdata;
      stall_err  = rsp_err;
      stall_w    = rsp_is_write;
    end
  end

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  en;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    chk("vec_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("vec_region_en", 64'(region_en), 64'(v.en));
    if (v.en != 3'b000) chk("vec_region_addr", 64'(region_addr), 64'(v.addr[15:0]));
    @(negedge clk);
    chk("vec_rsp_early", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("vec_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("vec_rsp_rdata", rsp_rdata, v.rdata);
    chk("vec_rsp_err", 64'(rsp_err), 64'(v.err));
    chk("vec_rsp_is_write", 64'(rsp_is_write), 64'(v.we));
  endtask

  task automatic drain(input string name);
    int k = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    while ((exp_q.size() != 0 || !req_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   nacc;
    int   stale;
    int   cyc;
    logic fire;

    vecs[0] = '{1'b1, 64'h0000_0000_0001_0040, 64'hA5A5, 3'b010, 64'h0, 1'b0};
    vecs[1] = '{1'b0, 64'h0000_0000_0002_0000, 64'h0, 3'b100, 64'h1, 1'b0};
    vecs[2] = '{1'b0, 64'h0000_0000_0001_0040, 64'h0, 3'b010, 64'hA5A5, 1'b0};
    vecs[3] = '{1'b0, 64'h0000_0000_000F_0000, 64'h0, 3'b000, 64'h0, 1'b1};
    vecs[4] = '{1'b1, 64'h0000_0000_0003_0008, 64'h77, 3'b000, 64'h0, 1'b1};
    vecs[5] = '{1'b0, 64'hFFF0_0000_0000_0005, 64'h0, 3'b001, 64'hA000_0000_0000_0005, 1'b0};

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_region_en", 64'(region_en), 64'(0));
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'(1));
`ifdef TPU_BRIDGE_ERRLOG_EN
    chk("rst_err_seen", 64'(err_seen), 64'(0));
`endif

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
`ifdef TPU_BRIDGE_ERRLOG_EN
      if (i >= 3) begin
        chk("errlog_seen", 64'(err_seen), 64'(1));
        chk("errlog_addr", err_addr, 64'h000F_0000);
      end
`endif
    end
    drain("drain_vectors");

    // Backpressure: only RSP_DEPTH requests accepted while rsp_ready is low
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; nacc = 0;
    for (int c = 0; c < 12; c++) begin
      req_addr = 64'((nacc % 3) << 16) | 64'(nacc);
      @(negedge clk);
      if (req_valid && req_ready) nacc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepts", 64'(nacc), 64'(4));
    chk("bp_req_ready", 64'(req_ready), 64'(0));
    chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    @(posedge clk); #1;
    drain("drain_bp");
    chk("bp_recover_ready", 64'(req_ready), 64'(1));

    // Full throughput with rsp_ready held high
    @(posedge clk); #1;
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; nacc = 0;
    for (int c = 0; c < 20; c++) begin
      req_addr = 64'((c % 3) << 16) | 64'(c % 16);
      @(negedge clk);
      if (req_valid && req_ready) nacc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("throughput_accepts", 64'(nacc), 64'(20));
    drain("drain_tput");

    // Reset with requests in flight
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; nacc = 0;
    for (int c = 0; c < 3; c++) begin
      req_addr = 64'(c << 16) | 64'(c + 1);
      @(negedge clk);
      if (req_valid && req_ready) nacc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rst = 1'b1;
    chk("inflight_accepts", 64'(nacc), 64'(3));
    @(negedge clk);
    chk("midrst_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("after_rst_req_ready", 64'(req_ready), 64'(1));
    chk("after_rst_region_en", 64'(region_en), 64'(0));
    rsp_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("no_stale_rsp", 64'(stale), 64'(0));
`ifdef TPU_BRIDGE_ERRLOG_EN
    chk("errlog_cleared", 64'(err_seen), 64'(0));
`endif

    // Randomized traffic with random response backpressure
    nacc = 0; cyc = 0;
    @(posedge clk); #1;
    while (nacc < 200 && cyc < 5000) begin
      @(negedge clk);
      fire = req_valid && req_ready;
      if (fire) nacc++;
      @(posedge clk); #1;
      cyc++;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (fire || !req_valid) begin
        if (nacc < 200 && $urandom_range(0, 3) != 0) begin
          int ridx;
          ridx      = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 15)) : int'($urandom_range(0, 2));
          req_we    = ($urandom_range(0, 1) == 1);
          req_addr  = {$urandom(), 32'h0} & 64'hFFFF_FFFF_FFF0_0000;
          req_addr  = req_addr | 64'(ridx << 16) | 64'($urandom_range(0, 16'hFFFF));
          req_wdata = {$urandom(), $urandom()};
          req_valid = 1'b1;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("random_accepts", 64'(nacc), 64'(200));
    drain("drain_random");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpu_host_bridge.md
Name: tpu_host_bridge

Overview:
- Parametrised host-side bridge: accepts single-beat host read/write requests and decodes them onto NUM_REGIONS local slave ports (icache, ubuf, status, ...).
- Returns in-order responses through a response FIFO, with valid/ready backpressure on both sides.
- Flags unmapped addresses as errors.
- Sits between the SoC host port and the TPU's storage/status blocks; successor to the fixed 3-way, non-backpressured host interface.

Parameters:
- NUM_REGIONS, 3, number of decoded slave regions (1..16)
- ADDR_W, 64, host address width
- DATA_W, 64, data width on host and region ports
- LOCAL_ADDR_W, 16, region-local address width, taken from addr[LOCAL_ADDR_W-1:0]
- REGION_SHIFT, 16, LSB of the region index field in addr
- REGION_IDX_W, 4, width of the region index field
- RD_LATENCY, 1, cycles from a region_en sample to a valid region_rdata (>=1)
- RSP_DEPTH, 4, response FIFO entries (>= RD_LATENCY+2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  unmapped region
- rsp_is_write  out  1  response belongs to a write
- region_en  out  NUM_REGIONS  one-hot access strobe
- region_we  out  1  shared write enable
- region_addr  out  LOCAL_ADDR_W  shared local address
- region_wdata  out  DATA_W  shared write data
- region_rdata  in  NUM_REGIONS x DATA_W  per-region read data
- err_addr  out  ADDR_W  first error address (only when TPU_BRIDGE_ERRLOG_EN is defined)
- err_seen  out  1  sticky error flag (only when TPU_BRIDGE_ERRLOG_EN is defined)

Behaviour:
- Reset: req_ready=0 during rst, 1 on the first cycle after. All other outputs, pipe stages and FIFO reset to 0/empty.
- Accept: at an edge where req_valid && req_ready. idx = req_addr[REGION_SHIFT +: REGION_IDX_W]. err = (idx >= NUM_REGIONS).
- Issue stage, registered, cycle T+1:
  - region_en[idx]=1 only if !err; otherwise region_en=0.
  - region_we, region_addr, region_wdata are registered copies of the request.
  - region_en is a 1-cycle pulse per accepted request. Back-to-back accepts give a strobe every cycle.
- Return pipe: a RD_LATENCY-deep shift register carries {valid, idx, err, we}. At the end of cycle T+1+RD_LATENCY, the bridge pushes {rdata = (we||err) ? 0 : region_rdata[idx], err, we} into the response FIFO.
- Response timing: at the FIFO head, rsp_valid is first seen at T+2+RD_LATENCY (T+3 at default). There is no bypass.
- Ordering: responses come out strictly in acceptance order. Writes, reads and errors all take the same fixed-length path.
- Credit: req_ready = !rst && (fifo_count + inflight + 1 <= RSP_DEPTH).
  - inflight counts valid issue and pipe stages.
  - req_ready depends on registers only, never combinationally on req_valid.
- FIFO:
  - Pop on rsp_valid && rsp_ready. Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo RSP_DEPTH.
  - The credit rule guarantees no push when full. A push-when-full is an assertion failure.
- rsp_valid/rsp_rdata/rsp_err/rsp_is_write stay stable while rsp_valid && !rsp_ready.
- A rst asserted mid-transaction discards all in-flight and queued responses. No region strobe is emitted in the cycle after rst.
- Full throughput: 1 req/cycle when rsp_ready is held at 1.

Optional Feature:
- TPU_BRIDGE_ERRLOG_EN defined:
  - err_seen sets on the first accepted unmapped request; err_addr captures its full address.
  - Both hold until rst. Later errors do not overwrite.
- Not defined: err_addr and err_seen ports and their logic are absent. rsp_err is still produced.

Decomposition:
- Package tpu_bridge_pkg: rsp_entry_t struct {rdata, err, is_write}, pipe_entry_t struct {valid, idx, err, we}, function region_idx(addr).
- Sub-module tpu_bridge_rsp_fifo: parametrised sync FIFO of rsp_entry_t with count output. Instantiated once.

Test Plan:
- Write addr 0x0001_0040, data 0xA5A5: region_en=3'b010, region_addr=0x0040 at T+1; rsp_valid at T+3 with is_write=1, rdata=0, err=0.
- Read region 2 (status), model returns 0x1 one cycle later: rsp_rdata=0x1 at T+3, err=0.
- Read addr 0x000F_0000 (idx 15): no region_en; rsp_err=1, rdata=0. With TPU_BRIDGE_ERRLOG_EN: err_addr=0x000F_0000, err_seen=1; a second error leaves err_addr unchanged.
- Hold rsp_ready=0 and stream reads: exactly RSP_DEPTH accepts, then req_ready=0 with no overflow. Release rsp_ready: data is returned in order and req_ready recovers.
- Randomised mix of 200 reads/writes across 3 regions with random rsp_ready: scoreboard confirms in-order data and one region_en pulse per non-error request.
- Assert rst with 3 requests in flight: after reset, rsp_valid=0, no stale response appears, and req_ready=1 the cycle after reset.
